// File: rtl/filter_sp_pkg.sv
// Shared types and default sizes for the filter scratchpad controller.
package filter_sp_pkg;
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        READ = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam int DEF_FILTER_WIDTH = 16;
    localparam int DEF_FILTER_ROW   = 12;
endpackage

// File: rtl/filter_addr_cnt.sv
// Modulo-len address counter; o_wrap flags the advancing step that returns to 0.
module filter_addr_cnt
    import filter_sp_pkg::*;
#(
    parameter int AW = 4,
    parameter int LW = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_clr,
    input  logic          i_en,
    input  logic [LW-1:0] i_len,
    output logic [AW-1:0] o_cnt,
    output logic          o_wrap
);
    logic [AW-1:0] r_cnt;

    assign o_cnt  = r_cnt;
    assign o_wrap = i_en && (LW'(r_cnt) == i_len - LW'(1));

    always_ff @(posedge clk) begin
        if (rst || i_clr) begin
            r_cnt <= '0;
        end else if (i_en) begin
            r_cnt <= o_wrap ? '0 : r_cnt + AW'(1);
        end
    end
endmodule

// File: rtl/filter_sp_ctrl.sv
// Loads a filter into an external scratchpad, then replays it num_passes times
// on a valid/ready stream; a resident filter can be replayed without reloading.
module filter_sp_ctrl
    import filter_sp_pkg::*;
#(
    parameter int FILTER_WIDTH = DEF_FILTER_WIDTH,
    parameter int FILTER_ROW   = DEF_FILTER_ROW,
    localparam int AW = $clog2(FILTER_ROW),
    localparam int LW = $clog2(FILTER_ROW + 1)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic                    reuse,
    input  logic [LW-1:0]           filter_len,
    input  logic [7:0]              num_passes,
    input  logic                    in_valid,
    input  logic [FILTER_WIDTH-1:0] in_data,
    output logic                    in_ready,
    output logic                    out_valid,
    output logic [FILTER_WIDTH-1:0] out_data,
    output logic                    out_last,
    input  logic                    out_ready,
    output logic [FILTER_WIDTH-1:0] sp_din,
    output logic [AW-1:0]           sp_waddr,
    output logic [AW-1:0]           sp_raddr,
    output logic                    sp_wen,
    output logic                    sp_ren,
    output logic                    sp_chip_en,
    input  logic [FILTER_WIDTH-1:0] sp_dout,
    output logic                    busy,
    output logic                    done,
    output logic                    err
);
    state_t        r_state, w_next;
    logic [LW-1:0] r_len;
    logic [7:0]    r_passes, r_pass_cnt;
    logic          r_resident, r_rd_done, r_out_valid, r_out_last, r_err;
    logic          w_len_ok, w_accept, w_reject, w_wen, w_ren;
    logic          w_wr_wrap, w_rd_wrap, w_final_rd;
    logic [AW-1:0] w_wcnt, w_rcnt;

    assign w_len_ok = (filter_len != '0) && (filter_len <= LW'(FILTER_ROW));
    assign w_accept = (r_state == IDLE) && start && w_len_ok && (!reuse || r_resident);
    assign w_reject = (r_state == IDLE) && start && !(w_len_ok && (!reuse || r_resident));

    assign w_wen = (r_state == LOAD) && in_valid;
    // A read is issued only when the output register is free or being drained.
    assign w_ren = (r_state == READ) && !r_rd_done && (!r_out_valid || out_ready);
    assign w_final_rd = w_rd_wrap && (r_pass_cnt == r_passes - 8'd1);

    filter_addr_cnt #(.AW(AW), .LW(LW)) u_wr_cnt (
        .clk(clk), .rst(rst), .i_clr(w_accept), .i_en(w_wen),
        .i_len(r_len), .o_cnt(w_wcnt), .o_wrap(w_wr_wrap)
    );

    filter_addr_cnt #(.AW(AW), .LW(LW)) u_rd_cnt (
        .clk(clk), .rst(rst), .i_clr(w_accept), .i_en(w_ren),
        .i_len(r_len), .o_cnt(w_rcnt), .o_wrap(w_rd_wrap)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_len       <= '0;
            r_passes    <= '0;
            r_pass_cnt  <= '0;
            r_resident  <= 1'b0;
            r_rd_done   <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_state <= w_next;
            r_err   <= w_reject;
            if (w_accept) begin
                r_len      <= filter_len;
                r_passes   <= (num_passes == 8'd0) ? 8'd1 : num_passes;
                r_pass_cnt <= '0;
                r_rd_done  <= 1'b0;
                if (!reuse) r_resident <= 1'b0;
            end
            if (w_wr_wrap) r_resident <= 1'b1;
            if (w_rd_wrap) r_pass_cnt <= r_pass_cnt + 8'd1;
            if (w_final_rd) r_rd_done <= 1'b1;
            if (w_ren) begin
                r_out_valid <= 1'b1;
                r_out_last  <= w_final_rd;
            end else if (out_ready) begin
                r_out_valid <= 1'b0;
                r_out_last  <= 1'b0;
            end
        end
    end

    always_comb begin
        w_next     = r_state;
        in_ready   = 1'b0;
        sp_chip_en = 1'b0;
        busy       = 1'b1;
        done       = 1'b0;
        case (r_state)
            IDLE: begin
                busy = 1'b0;
                if (w_accept) w_next = reuse ? READ : LOAD;
            end
            LOAD: begin
                in_ready   = 1'b1;
                sp_chip_en = 1'b1;
                if (w_wr_wrap) w_next = READ;
            end
            READ: begin
                sp_chip_en = 1'b1;
                if (r_out_valid && out_ready && r_out_last) w_next = DONE;
            end
            DONE: begin
                done   = 1'b1;
                w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    // Address and data buses are zero whenever their strobe is idle.
    assign sp_wen    = w_wen;
    assign sp_ren    = w_ren;
    assign sp_din    = w_wen ? in_data : '0;
    assign sp_waddr  = w_wen ? w_wcnt : '0;
    assign sp_raddr  = w_ren ? w_rcnt : '0;
    assign out_valid = r_out_valid;
    assign out_last  = r_out_last;
    assign out_data  = r_out_valid ? sp_dout : '0;
    assign err       = r_err;
endmodule

// File: tb/tb_filter_sp_ctrl.sv
// Scoreboard bench for filter_sp_ctrl with a behavioural 1-cycle-read scratchpad.
module tb_filter_sp_ctrl;
    import filter_sp_pkg::*;

    localparam int FW = 16;
    localparam int FR = 12;
    localparam int AW = $clog2(FR);
    localparam int LW = $clog2(FR + 1);

    logic          clk = 1'b0;
    logic          rst, start, reuse, in_valid, out_ready;
    logic [LW-1:0] filter_len;
    logic [7:0]    num_passes;
    logic [FW-1:0] in_data, out_data, sp_din, sp_dout;
    logic          in_ready, out_valid, out_last;
    logic [AW-1:0] sp_waddr, sp_raddr;
    logic          sp_wen, sp_ren, sp_chip_en, busy, done, err;

    logic [FW-1:0] mem [0:FR-1];
    logic [FW-1:0] res_w [0:FR-1];
    logic [FW:0]   exp_q [$];
    logic [AW-1:0] wa_log [$];
    logic [FW-1:0] wd_log [$];

    int n_vec = 0, n_err = 0, cyc = 0, done_cnt = 0;
    int last_hs = -1, done_cyc = -1, first_ren = -1, first_ov = -1, last_wr = -1;

    always #5 clk = ~clk;

    filter_sp_ctrl #(.FILTER_WIDTH(FW), .FILTER_ROW(FR)) dut (
        .clk(clk), .rst(rst), .start(start), .reuse(reuse),
        .filter_len(filter_len), .num_passes(num_passes),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .out_valid(out_valid), .out_data(out_data), .out_last(out_last),
        .out_ready(out_ready), .sp_din(sp_din), .sp_waddr(sp_waddr),
        .sp_raddr(sp_raddr), .sp_wen(sp_wen), .sp_ren(sp_ren),
        .sp_chip_en(sp_chip_en), .sp_dout(sp_dout),
        .busy(busy), .done(done), .err(err)
    );

    always @(posedge clk) begin
        if (sp_chip_en && sp_wen) mem[sp_waddr] <= sp_din;
        if (sp_chip_en && sp_ren) sp_dout <= mem[sp_raddr];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_vec++;
        if (obs !== expv) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", tag, obs, expv, cyc);
        end
    endtask

    // Sample everything on the falling edge, return just after the rising edge.
    task automatic step();
        logic [FW:0] e;
        @(negedge clk);
        cyc++;
        if (sp_wen && sp_ren) chk("wen_ren_excl", 32'({sp_wen, sp_ren}), 32'd0);
        if (sp_wen) begin
            wa_log.push_back(sp_waddr);
            wd_log.push_back(sp_din);
            last_wr = cyc;
        end
        if (sp_ren && first_ren < 0) first_ren = cyc;
        if (out_valid && first_ov < 0) first_ov = cyc;
        if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                chk("extra_word", 32'({1'b1, out_data}), 32'd0);
            end else begin
                e = exp_q.pop_front();
                chk("out_data", 32'(out_data), 32'(e[FW-1:0]));
                chk("out_last", 32'(out_last), 32'(e[FW]));
            end
            if (out_last) last_hs = cyc;
        end
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle(input string tag);
        chk({tag, "_ctl"}, 32'({busy, out_valid, out_last, in_ready, sp_wen,
                                sp_ren, sp_chip_en, done, err}), 32'd0);
        chk({tag, "_addr"}, 32'({sp_waddr, sp_raddr}), 32'd0);
        chk({tag, "_data"}, 32'({sp_din, out_data}), 32'd0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic begin_job();
        wa_log.delete();
        wd_log.delete();
        first_ren = -1;
        first_ov  = -1;
        last_wr   = -1;
        last_hs   = -1;
    endtask

    task automatic push_exp(input int len, input int passes);
        int p;
        p = (passes == 0) ? 1 : passes;
        for (int pp = 0; pp < p; pp++)
            for (int i = 0; i < len; i++)
                exp_q.push_back({(pp == p - 1) && (i == len - 1), res_w[i]});
    endtask

    task automatic start_job(input int len, input int passes, input logic ru);
        filter_len = LW'(len);
        num_passes = 8'(passes);
        reuse      = ru;
        start      = 1'b1;
        step();
        start      = 1'b0;
        reuse      = 1'b0;
    endtask

    task automatic load_word(input logic [FW-1:0] d);
        int n;
        n = 0;
        in_valid = 1'b1;
        in_data  = d;
        while (!in_ready && n < 20) begin
            step();
            n++;
        end
        chk("in_ready", 32'(in_ready), 32'd1);
        step();
        in_valid = 1'b0;
    endtask

    task automatic run_job(input int bound);
        int d0, n;
        d0 = done_cnt;
        n  = 0;
        while (done_cnt == d0 && n < bound) begin
            step();
            n++;
        end
        chk("done_seen", 32'(done_cnt - d0), 32'd1);
        chk("exp_drained", 32'(exp_q.size()), 32'd0);
        chk("done_latency", 32'(done_cyc - last_hs), 32'd1);
        chk("busy_after_done", 32'(busy), 32'd0);
    endtask

    initial begin
        logic [FW-1:0] held;
        int d0, n;
        rst = 1'b1; start = 1'b0; reuse = 1'b0; filter_len = '0; num_passes = '0;
        in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
        do_reset();
        check_idle("reset");

        // len 3, two passes, fresh load
        begin_job();
        res_w[0] = 16'hA1A1; res_w[1] = 16'hB2B2; res_w[2] = 16'hC3C3;
        push_exp(3, 2);
        start_job(3, 2, 1'b0);
        chk("job1_err", 32'(err), 32'd0);
        chk("job1_busy", 32'(busy), 32'd1);
        for (int i = 0; i < 3; i++) load_word(res_w[i]);
        run_job(60);
        chk("job1_nwr", 32'(wa_log.size()), 32'd3);
        for (int i = 0; i < 3 && i < wa_log.size(); i++) begin
            chk("job1_waddr", 32'(wa_log[i]), 32'(i));
            chk("job1_wdata", 32'(wd_log[i]), 32'(res_w[i]));
        end
        chk("job1_ren_lat", 32'(first_ren - last_wr), 32'd1);
        chk("job1_ov_lat", 32'(first_ov - first_ren), 32'd1);

        // reuse with a 3-cycle output stall mid-stream
        begin_job();
        push_exp(3, 3);
        start_job(3, 3, 1'b1);
        chk("stall_busy", 32'(busy), 32'd1);
        repeat (4) step();
        out_ready = 1'b0;
        held = out_data;
        chk("stall_valid0", 32'(out_valid), 32'd1);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("stall_valid", 32'(out_valid), 32'd1);
            chk("stall_hold", 32'(out_data), 32'(held));
            chk("stall_noren", 32'(sp_ren), 32'd0);
        end
        out_ready = 1'b1;
        run_job(60);
        chk("stall_noload", 32'(wa_log.size()), 32'd0);

        // reuse, one pass, with a stray start while busy
        begin_job();
        push_exp(3, 1);
        start_job(3, 1, 1'b1);
        start = 1'b1; filter_len = LW'(5); num_passes = 8'd9;
        step();
        step();
        start = 1'b0;
        run_job(40);
        chk("reuse_noload", 32'(wa_log.size()), 32'd0);

        // reset drops the resident filter
        do_reset();
        start_job(3, 1, 1'b1);
        chk("reuse_rst_err", 32'(err), 32'd1);
        chk("reuse_rst_busy", 32'(busy), 32'd0);
        step();
        chk("err_pulse_end", 32'(err), 32'd0);

        // illegal lengths
        start_job(0, 1, 1'b0);
        chk("len0_err", 32'(err), 32'd1);
        chk("len0_busy", 32'(busy), 32'd0);
        start_job(13, 1, 1'b0);
        chk("len13_err", 32'(err), 32'd1);
        chk("len13_busy", 32'(busy), 32'd0);
        step();
        chk("len13_err_end", 32'(err), 32'd0);

        // full depth, two passes (address wrap at 11)
        begin_job();
        for (int i = 0; i < FR; i++) res_w[i] = FW'(16'h1000 + i * 16'h0111);
        push_exp(12, 2);
        start_job(12, 2, 1'b0);
        chk("len12_err", 32'(err), 32'd0);
        for (int i = 0; i < FR; i++) load_word(res_w[i]);
        run_job(120);
        chk("len12_nwr", 32'(wa_log.size()), 32'd12);
        if (wa_log.size() == 12) chk("len12_lastaddr", 32'(wa_log[11]), 32'd11);

        // passes 0 behaves as a single pass
        begin_job();
        push_exp(3, 0);
        start_job(3, 0, 1'b1);
        run_job(40);

        // reset while the second word is being read
        begin_job();
        push_exp(12, 1);
        start_job(12, 1, 1'b1);
        n = 0;
        while (!(sp_ren && sp_raddr == AW'(1)) && n < 40) begin
            step();
            n++;
        end
        chk("rst_found_rd1", 32'({sp_ren, sp_raddr}), 32'({1'b1, AW'(1)}));
        d0 = done_cnt;
        rst = 1'b1;
        step();
        check_idle("midread_rst");
        rst = 1'b0;
        exp_q.delete();
        repeat (3) step();
        chk("midread_nodone", 32'(done_cnt - d0), 32'd0);
        chk("midread_busy", 32'(busy), 32'd0);
        start_job(3, 1, 1'b1);
        chk("midread_reuse_err", 32'(err), 32'd1);

        // gapped load stream
        begin_job();
        res_w[0] = 16'h0D0D; res_w[1] = 16'h0E0E; res_w[2] = 16'h0F0F;
        push_exp(3, 1);
        start_job(3, 1, 1'b0);
        load_word(res_w[0]);
        step();
        load_word(res_w[1]);
        step();
        load_word(res_w[2]);
        run_job(40);
        chk("gap_nwr", 32'(wa_log.size()), 32'd3);
        for (int i = 0; i < 3 && i < wa_log.size(); i++)
            chk("gap_waddr", 32'(wa_log[i]), 32'(i));
        chk("gap_ren_lat", 32'(first_ren - last_wr), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
